// File: rtl/terc_decoder.sv
// terc_decoder: instruction register, 4-phase sequencer and control-strobe decode for the terc core.
// The IR is loaded on the edge that ends FETCH; selects are decoded from the IR and strobes from
// the current phase, the IR and hold.
module terc_decoder #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned OP_WIDTH  = 4,
  parameter int unsigned REG_WIDTH = 3,
  parameter int unsigned IM_WIDTH  = 9
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [WIDTH-1:0]     inst,
  input  logic                 hold,
  output logic [1:0]           state,
  output logic [OP_WIDTH-1:0]  op,
  output logic [REG_WIDTH-1:0] lSel,
  output logic [REG_WIDTH-1:0] rSel,
  output logic [REG_WIDTH-1:0] oSel,
  output logic [WIDTH-1:0]     imm,
  output logic                 immSel,
  output logic                 LOUTdec,
  output logic                 ROUTdec,
  output logic                 OINdec,
  output logic                 CSdec,
  output logic                 RW,
  output logic                 illegal,
  output logic [15:0]          retired
);

  localparam logic [1:0] StFetch  = 2'd0;
  localparam logic [1:0] StDecode = 2'd1;
  localparam logic [1:0] StExec   = 2'd2;
  localparam logic [1:0] StWrite  = 2'd3;

  // Field positions, counted down from the top of the word.
  localparam int unsigned OpLsb = WIDTH - OP_WIDTH;
  localparam int unsigned RdLsb = OpLsb - REG_WIDTH;
  localparam int unsigned RsLsb = RdLsb - REG_WIDTH;
  localparam int unsigned RtLsb = RsLsb - REG_WIDTH;

  localparam logic [OP_WIDTH-1:0] OpAluLast = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OpLoadi   = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OpLoad    = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OpStore   = OP_WIDTH'(8);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [15:0]      retired_q, retired_d;

  logic [OP_WIDTH-1:0]  op_w;
  logic [REG_WIDTH-1:0] rd_w, rs_w, rt_w;
  logic                 is_alu, is_loadi, is_load, is_store;

  assign op_w = ir_q[OpLsb +: OP_WIDTH];
  assign rd_w = ir_q[RdLsb +: REG_WIDTH];
  assign rs_w = ir_q[RsLsb +: REG_WIDTH];
  assign rt_w = ir_q[RtLsb +: REG_WIDTH];

  assign is_alu   = (op_w <= OpAluLast);
  assign is_loadi = (op_w == OpLoadi);
  assign is_load  = (op_w == OpLoad);
  assign is_store = (op_w == OpStore);

  // Next-state: advance phase, latch IR at end of FETCH, count retirement at end of WRITE.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    if (!hold) begin
      state_d = state_q + 2'd1;
      if (state_q == StFetch) begin
        ir_d = inst;
      end
      if (state_q == StWrite) begin
        retired_d = retired_q + 16'd1;
      end
    end
  end

  // State registers with synchronous active-low reset that overrides hold.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Register selects and immediate, decoded purely from the IR.
  always_comb begin
    lSel   = '0;
    rSel   = '0;
    oSel   = '0;
    immSel = 1'b0;
    if (is_alu) begin
      lSel = rs_w;
      rSel = rt_w;
      oSel = rd_w;
    end else if (is_loadi) begin
      oSel   = rd_w;
      immSel = 1'b1;
    end else if (is_load) begin
      lSel = rs_w;
      oSel = rd_w;
    end else if (is_store) begin
      // STORE puts the address register in the rd slot.
      lSel = rd_w;
      rSel = rs_w;
    end
  end

  // Per-phase strobes; hold suppresses them so a phase never strobes twice.
  always_comb begin
    LOUTdec = 1'b0;
    ROUTdec = 1'b0;
    OINdec  = 1'b0;
    CSdec   = 1'b0;
    RW      = 1'b1;
    if (!hold) begin
      case (state_q)
        StExec: begin
          if (is_alu) begin
            LOUTdec = 1'b1;
            ROUTdec = 1'b1;
          end else if (is_load) begin
            LOUTdec = 1'b1;
            CSdec   = 1'b1;
          end else if (is_store) begin
            LOUTdec = 1'b1;
            ROUTdec = 1'b1;
            CSdec   = 1'b1;
            RW      = 1'b0;
          end
        end
        StWrite: begin
          if (is_alu || is_loadi) begin
            OINdec = 1'b1;
          end else if (is_load) begin
            CSdec  = 1'b1;
            OINdec = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign op      = op_w;
  assign imm     = {{(WIDTH - IM_WIDTH){1'b0}}, ir_q[IM_WIDTH-1:0]};
  assign illegal = !(is_alu || is_loadi || is_load || is_store);
  assign retired = retired_q;

endmodule

// File: tb/tb_terc_decoder.sv
// Scoreboard bench for terc_decoder: the driver pushes hand-computed expectations per cycle,
// a monitor on the falling edge pops and compares them.
module tb_terc_decoder;

  logic        clk = 1'b0;
  logic        res;
  logic [15:0] inst;
  logic        hold;
  logic [1:0]  state;
  logic [3:0]  op;
  logic [2:0]  lSel, rSel, oSel;
  logic [15:0] imm;
  logic        immSel, LOUTdec, ROUTdec, OINdec, CSdec, RW, illegal;
  logic [15:0] retired;

  terc_decoder dut (
    .clk     (clk),
    .res     (res),
    .inst    (inst),
    .hold    (hold),
    .state   (state),
    .op      (op),
    .lSel    (lSel),
    .rSel    (rSel),
    .oSel    (oSel),
    .imm     (imm),
    .immSel  (immSel),
    .LOUTdec (LOUTdec),
    .ROUTdec (ROUTdec),
    .OINdec  (OINdec),
    .CSdec   (CSdec),
    .RW      (RW),
    .illegal (illegal),
    .retired (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  l;
    logic [2:0]  r;
    logic [2:0]  o;
    logic [15:0] imm;
    logic        immsel;
    logic        ill;
  } dec_t;

  typedef struct {
    int          tag;
    logic [1:0]  st;
    dec_t        d;
    logic [4:0]  stb;  // {LOUTdec, ROUTdec, OINdec, CSdec, RW}
    logic [15:0] ret;
  } exp_t;

  localparam logic [4:0] Idle = 5'b00001;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          step_no = 0;
  logic [15:0] exp_ret = 16'd0;
  dec_t        prev_d = '0;

  function automatic dec_t mk(input logic [3:0] o_p, input logic [2:0] l, input logic [2:0] r,
                              input logic [2:0] o, input logic [15:0] im, input logic is,
                              input logic il);
    dec_t d;
    d.op = o_p; d.l = l; d.r = r; d.o = o; d.imm = im; d.immsel = is; d.ill = il;
    return d;
  endfunction

  task automatic chk(input string name, input int tag, input logic [15:0] act,
                     input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, tag, act, want);
    end
  endtask

  task automatic push(input logic [1:0] st, input dec_t d, input logic [4:0] stb);
    exp_t e;
    e.tag = step_no; e.st = st; e.d = d; e.stb = stb; e.ret = exp_ret;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    step_no++;
  endtask

  // One instruction through all four phases, starting while the DUT sits in FETCH.
  task automatic run_inst(input logic [15:0] instr, input dec_t d, input logic [4:0] ex,
                          input logic [4:0] wr, input int hold_n, input bit rst_exec,
                          input bit wrap);
    step();
    res = 1'b1; hold = 1'b0; inst = instr;
    push(2'd0, prev_d, Idle);
    step();
    inst = ~instr;  // IR must already hold the word
    if (wrap) begin
      force dut.retired_q = 16'hFFFF;
      exp_ret = 16'hFFFF;
      #1 release dut.retired_q;
    end
    push(2'd1, d, Idle);
    for (int i = 0; i < hold_n; i++) begin
      step();
      hold = 1'b1;
      push(2'd2, d, Idle);
    end
    step();
    hold = 1'b0;
    if (rst_exec) res = 1'b0;
    push(2'd2, d, ex);
    if (rst_exec) begin
      exp_ret = 16'd0;
      prev_d  = '0;
      return;
    end
    step();
    push(2'd3, d, wr);
    exp_ret = exp_ret + 16'd1;
    prev_d  = d;
  endtask

  // Monitor: compare every presented cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state", e.tag, {14'd0, state}, {14'd0, e.st});
        chk("op", e.tag, {12'd0, op}, {12'd0, e.d.op});
        chk("lSel", e.tag, {13'd0, lSel}, {13'd0, e.d.l});
        chk("rSel", e.tag, {13'd0, rSel}, {13'd0, e.d.r});
        chk("oSel", e.tag, {13'd0, oSel}, {13'd0, e.d.o});
        chk("imm", e.tag, imm, e.d.imm);
        chk("immSel", e.tag, {15'd0, immSel}, {15'd0, e.d.immsel});
        chk("illegal", e.tag, {15'd0, illegal}, {15'd0, e.d.ill});
        chk("strobes", e.tag, {11'd0, LOUTdec, ROUTdec, OINdec, CSdec, RW}, {11'd0, e.stb});
        chk("retired", e.tag, retired, e.ret);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    dec_t loadi, add, sub, store, load, ill_f, ill_9, nop;
    loadi = mk(4'h6, 3'd0, 3'd0, 3'd3, 16'h0009, 1'b1, 1'b0);  // 6609 LOADI r3,9
    add   = mk(4'h0, 3'd3, 3'd4, 3'd2, 16'h00E0, 1'b0, 1'b0);  // 04E0 ADD r2,r3,r4
    sub   = mk(4'h1, 3'd5, 3'd6, 3'd7, 16'h0170, 1'b0, 1'b0);  // 1F70 SUB r7,r5,r6
    store = mk(4'h8, 3'd1, 3'd5, 3'd0, 16'h0140, 1'b0, 1'b0);  // 8340 STORE [r1]<-r5
    load  = mk(4'h7, 3'd1, 3'd0, 3'd5, 16'h0040, 1'b0, 1'b0);  // 7A40 LOAD r5<-[r1]
    ill_f = mk(4'hF, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1);  // F000
    ill_9 = mk(4'h9, 3'd0, 3'd0, 3'd0, 16'h01FF, 1'b0, 1'b1);  // 91FF
    nop   = mk(4'h6, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 1'b0);  // 6000 LOADI r0,0

    res = 1'b0; hold = 1'b1; inst = 16'h1234;
    repeat (3) @(posedge clk);
    #1;

    run_inst(16'h6609, loadi, Idle,     5'b00101, 0, 1'b0, 1'b0);
    run_inst(16'h04E0, add,   5'b11001, 5'b00101, 0, 1'b0, 1'b0);
    run_inst(16'h8340, store, 5'b11010, 5'b00001, 0, 1'b0, 1'b0);
    run_inst(16'h7A40, load,  5'b10011, 5'b00111, 0, 1'b0, 1'b0);
    run_inst(16'h04E0, add,   5'b11001, 5'b00101, 3, 1'b0, 1'b0);
    run_inst(16'hF000, ill_f, Idle,     Idle,     0, 1'b0, 1'b0);
    run_inst(16'h1F70, sub,   5'b11001, 5'b00101, 0, 1'b0, 1'b0);
    run_inst(16'h91FF, ill_9, Idle,     Idle,     0, 1'b0, 1'b0);
    run_inst(16'h8340, store, 5'b11010, 5'b00001, 0, 1'b1, 1'b0);
    run_inst(16'h6609, loadi, Idle,     5'b00101, 0, 1'b0, 1'b0);
    run_inst(16'h6000, nop,   Idle,     5'b00101, 0, 1'b0, 1'b1);
    run_inst(16'h04E0, add,   5'b11001, 5'b00101, 0, 1'b0, 1'b0);

    step();
    hold = 1'b0;
    push(2'd0, prev_d, Idle);
    step();
    hold = 1'b1;
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", step_no, 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/terc_decoder.md
Name: terc_decoder

Overview:
- Instruction decoder and phase sequencer for the terc core.
- Accepts the 16-bit instruction word that the bench or fetch side encodes (R-type, LOADI, memory type).
- Steps a 4-phase CPU cycle and produces the register-file selects, immediate, and per-phase control strobes (LOUTdec, ROUTdec, OINdec, CSdec, RW) consumed by the register file and memory.
- It is the decode end of the instruction encoding used by the bench encoder functions.

Parameters:
WIDTH, 16, instruction and data width
OP_WIDTH, 4, opcode field width, inst[15:12]
REG_WIDTH, 3, register index width
IM_WIDTH, 9, LOADI immediate width, inst[8:0]

Ports:
clk  in  1  clock, rising edge
res  in  1  synchronous active-low reset
inst  in  WIDTH  instruction word, sampled in FETCH
hold  in  1  freeze sequencer when 1
state  out  2  0=FETCH 1=DECODE 2=EXEC 3=WRITE
op  out  OP_WIDTH  IR[15:12]
lSel  out  REG_WIDTH  left-operand register select
rSel  out  REG_WIDTH  right-operand register select
oSel  out  REG_WIDTH  destination register select
imm  out  WIDTH  zero-extended IR[8:0]
immSel  out  1  1 = write-back source is imm (LOADI)
LOUTdec  out  1  left register output enable
ROUTdec  out  1  right register output enable
OINdec  out  1  destination register write enable
CSdec  out  1  memory chip select
RW  out  1  1=read, 0=write
illegal  out  1  undefined opcode in IR
retired  out  16  instructions completed, wraps

Behaviour:
- Encodings (fixed):
  - R-type: {op, rd[11:9], rs[8:6], rt[5:3], 000}.
  - LOADI: {4'h6, rd, im[8:0]}.
  - Memory: {op, rd, rs, 6'b0}.
- Opcodes: 0x0–0x5 ALU (ADD, SUB, AND, OR, XOR, SHL); 0x6 LOADI; 0x7 LOAD; 0x8 STORE; 0x9–0xF illegal.
- Reset: at any edge with res=0, all of the following are cleared, overriding hold and any phase in progress:
  - state=FETCH, IR=16'h0000, retired=0.
  - Outputs then read: strobes 0, selects 0, imm 0, immSel 0, illegal 0, RW=1.
- Sequencer: with hold=0, state advances every edge FETCH→DECODE→EXEC→WRITE→FETCH. One instruction per 4 clocks.
- FETCH edge: IR<=inst, so inst must be stable at the rising edge that ends FETCH.
- hold=1: state, IR and retired keep their values, and all strobes are forced 0. Strobes resume for the current phase once hold returns to 0, so no strobe is ever asserted twice for one instruction phase.
- Selects, op, imm, immSel and illegal are combinational from IR. They are valid in DECODE, EXEC and WRITE; in FETCH they reflect the previous IR.
- Select mapping:
  - ALU: lSel=rs, rSel=rt, oSel=rd.
  - LOADI: oSel=rd, immSel=1.
  - LOAD: lSel=rs (address), oSel=rd.
  - STORE: lSel=rd (address), rSel=rs (data).
  - Unused selects are 0.
- Strobes are combinational from state, IR and hold; they are 0 in FETCH and DECODE.
- EXEC strobes:
  - ALU: LOUTdec=1, ROUTdec=1.
  - LOAD: LOUTdec=1, CSdec=1, RW=1.
  - STORE: LOUTdec=1, ROUTdec=1, CSdec=1, RW=0.
  - RW=1 whenever it is not STORE in EXEC.
- WRITE strobes:
  - ALU: OINdec=1.
  - LOADI: OINdec=1.
  - LOAD: CSdec=1, RW=1, OINdec=1.
  - STORE: no strobes.
- Illegal opcodes: illegal=1 in DECODE–WRITE, no strobes; the instruction still counts as retired.
- retired increments on the WRITE→FETCH edge when hold=0; 16'hFFFF wraps to 0.
- After reset the first instruction comes from inst sampled on the first FETCH edge; IR=0 is never executed.

Test Plan:
- Reset then release, inst=16'h6609 (LOADI r3,9) → DECODE: oSel=3, imm=16'h0009, immSel=1; WRITE: OINdec=1; retired=1 after 4 clocks.
- inst=16'h04E0 (ADD r2,r3,r4) → lSel=3, rSel=4, oSel=2; EXEC: LOUTdec=ROUTdec=1, CSdec=0; WRITE: OINdec=1.
- inst=16'h8340 (STORE rd=1, rs=5) → lSel=1, rSel=5; EXEC: CSdec=1, RW=0; WRITE: all strobes 0. Follow with inst=16'h7A40 (LOAD r5←[r1]) → lSel=1, oSel=5; EXEC and WRITE: CSdec=1, RW=1; WRITE: OINdec=1.
- hold=1 for 3 clocks while in EXEC of ADD → state stays 2, strobes 0, retired unchanged; on release LOUTdec/ROUTdec assert for exactly 1 clock, then WRITE follows.
- inst=16'hF000 → illegal=1 in DECODE–WRITE, no strobes, retired still increments. Separately, res=0 asserted in EXEC of STORE → next cycle state=0, CSdec=0, RW=1, retired=0.
- Preload retired to 16'hFFFF via 65535 NOPs (LOADI r0,0) → one more instruction wraps retired to 0.
